// File: rtl/thermal_pkg.sv
// rtl/thermal_pkg.sv - shared types and constants for the thermal sensor array
package thermal_pkg;

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    localparam int DEF_NCH       = 4;
    localparam int DEF_TW        = 7;
    localparam int DEF_FW        = 3;
    localparam int DEF_TICK_DIV  = 16;
    localparam int DEF_IDLE_TEMP = 30;
    localparam int DEF_LOAD_TEMP = 90;
    localparam int DEF_ALARM_HI  = 80;
    localparam int DEF_ALARM_LO  = 70;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/thermal_sensor_array_if.sv
// rtl/thermal_sensor_array_if.sv - round-robin scan sample stream
interface thermal_sensor_array_if #(
    parameter int NCH = 4,
    parameter int TW  = 7
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           sample_valid;
    logic           sample_ready;
    logic [CHW-1:0] sample_ch;
    logic [TW-1:0]  sample_temp;

    modport master (output sample_valid, output sample_ch, output sample_temp, input sample_ready);
    modport slave  (input sample_valid, input sample_ch, input sample_temp, output sample_ready);

endinterface

// File: rtl/thermal_channel.sv
// rtl/thermal_channel.sv - one sensor channel: target select, saturating step, alarm hysteresis
module thermal_channel
    import thermal_pkg::*;
#(
    parameter int TW        = DEF_TW,
    parameter int FW        = DEF_FW,
    parameter int IDLE_TEMP = DEF_IDLE_TEMP,
    parameter int LOAD_TEMP = DEF_LOAD_TEMP,
    parameter int ALARM_HI  = DEF_ALARM_HI,
    parameter int ALARM_LO  = DEF_ALARM_LO
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          in_use,
    input  logic [FW-1:0] fan_speed,
    input  logic          noise,
    output logic [TW-1:0] temp,
    output logic          alarm
);
    localparam int XW = TW + 1;

    logic [TW-1:0] temp_d, temp_q;
    logic          alarm_d, alarm_q;
    logic [XW-1:0] temp_x, target, step_up, step_dn, sum, gap;

    always_comb begin
        temp_x  = {1'b0, temp_q};
        // fan cooling lowers the load target but never below idle
        if (!in_use || int'(fan_speed) >= (LOAD_TEMP - IDLE_TEMP))
            target = XW'(IDLE_TEMP);
        else
            target = XW'(LOAD_TEMP - int'(fan_speed));
        step_up = XW'({1'b0, noise}) + XW'(1);
        step_dn = XW'(1) + XW'(fan_speed != '0);
        sum     = temp_x + step_up;
        gap     = temp_x - target;

        temp_d = temp_q;
        if (tick) begin
            if (temp_x < target)
                temp_d = (sum > target) ? TW'(target) : TW'(sum);
            else if (temp_x > target)
                temp_d = (gap <= step_dn) ? TW'(target) : TW'(temp_x - step_dn);
        end

        alarm_d = alarm_q;
        if (temp_q >= TW'(ALARM_HI))
            alarm_d = 1'b1;
        else if (temp_q <= TW'(ALARM_LO))
            alarm_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_q  <= TW'(IDLE_TEMP);
            alarm_q <= 1'b0;
        end else begin
            temp_q  <= temp_d;
            alarm_q <= alarm_d;
        end
    end

    assign temp  = temp_q;
    assign alarm = alarm_q;

endmodule

// File: rtl/thermal_sensor_array.sv
// rtl/thermal_sensor_array.sv - multi-channel thermal sensor model with alarms and scan stream
module thermal_sensor_array
    import thermal_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int TW        = DEF_TW,
    parameter int FW        = DEF_FW,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int IDLE_TEMP = DEF_IDLE_TEMP,
    parameter int LOAD_TEMP = DEF_LOAD_TEMP,
    parameter int ALARM_HI  = DEF_ALARM_HI,
    parameter int ALARM_LO  = DEF_ALARM_LO
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NCH-1:0]          in_use,
    input  logic [FW-1:0]           fan_speed,
    input  logic [15:0]             seed,
    input  logic                    seed_load,
    output logic [NCH-1:0][TW-1:0]  temperature,
    output logic [NCH-1:0]          alarm,
    output logic [TW-1:0]           max_temp,
    output logic                    overrun,
    thermal_sensor_array_if.master  sample_if
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(TICK_DIV);

    logic [PW-1:0]  presc_d, presc_q;
    logic [15:0]    lfsr_d, lfsr_q;
    logic [TW-1:0]  max_d, max_q;
    logic           tick;

    scan_state_t    state_q;
    logic           valid_q, overrun_q;
    logic [CHW-1:0] ch_q, ch_nxt;
    logic [TW-1:0]  stemp_q;

    assign tick   = (presc_q == PW'(TICK_DIV - 1));
    assign ch_nxt = ch_q + CHW'(1);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        // a seed load wins over the tick shift in the same cycle
        if (seed_load)
            lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
        else if (tick)
            lfsr_d = lfsr_next(lfsr_q);
        else
            lfsr_d = lfsr_q;
        max_d = temperature[0];
        for (int i = 1; i < NCH; i++)
            if (temperature[i] > max_d)
                max_d = temperature[i];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            presc_q <= '0;
            lfsr_q  <= LFSR_RESET;
            max_q   <= TW'(IDLE_TEMP);
        end else begin
            presc_q <= presc_d;
            lfsr_q  <= lfsr_d;
            max_q   <= max_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        thermal_channel #(
            .TW(TW), .FW(FW), .IDLE_TEMP(IDLE_TEMP), .LOAD_TEMP(LOAD_TEMP),
            .ALARM_HI(ALARM_HI), .ALARM_LO(ALARM_LO)
        ) u_ch (
            .clk       (CLK),
            .rst_n     (nRST),
            .tick      (tick),
            .in_use    (in_use[i]),
            .fan_speed (fan_speed),
            .noise     (lfsr_q[i % 16]),
            .temp      (temperature[i]),
            .alarm     (alarm[i])
        );
    end

    // Samples capture the pre-update temperature; a tick mid-scan does not restart it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            ch_q      <= '0;
            stemp_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= tick && (state_q == S_SCAN);
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q <= S_SCAN;
                        valid_q <= 1'b1;
                        ch_q    <= '0;
                        stemp_q <= temperature[0];
                    end
                end
                S_SCAN: begin
                    if (sample_if.sample_ready) begin
                        if (ch_q == CHW'(NCH - 1)) begin
                            state_q <= S_IDLE;
                            valid_q <= 1'b0;
                        end else begin
                            ch_q    <= ch_nxt;
                            stemp_q <= temperature[ch_nxt];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign max_temp              = max_q;
    assign overrun               = overrun_q;
    assign sample_if.sample_valid = valid_q;
    assign sample_if.sample_ch    = ch_q;
    assign sample_if.sample_temp  = stemp_q;

endmodule

// File: tb/tb_thermal_sensor_array.sv
// tb/tb_thermal_sensor_array.sv - scoreboard bench for thermal_sensor_array
module tb_thermal_sensor_array;
    localparam int NCH = 4, TW = 7, FW = 3, TICK_DIV = 16;
    localparam int IDLE = 30, LOAD = 90, HI = 80, LO = 70;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NCH-1:0]         in_use;
    logic [FW-1:0]          fan;
    logic [15:0]            seed;
    logic                   seed_load;
    logic [NCH-1:0][TW-1:0] temperature;
    logic [NCH-1:0]         alarm;
    logic [TW-1:0]          max_temp;
    logic                   overrun;

    thermal_sensor_array_if #(.NCH(NCH), .TW(TW)) sif ();

    thermal_sensor_array #(.NCH(NCH), .TW(TW), .FW(FW), .TICK_DIV(TICK_DIV)) dut (
        .CLK(clk), .nRST(rst_n), .in_use(in_use), .fan_speed(fan), .seed(seed),
        .seed_load(seed_load), .temperature(temperature), .alarm(alarm),
        .max_temp(max_temp), .overrun(overrun), .sample_if(sif)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {int ch; int t;} samp_t;
    samp_t q[$];
    int    hs_ch[$];
    int    hs_count = 0;

    int          m_presc, m_ch, m_max, m_temp[NCH];
    bit          m_alarm[NCH];
    bit          m_scan, m_ovr, m_tick;
    logic [15:0] m_lfsr;
    int          tgt;

    // Reference model of the specified behaviour; pushes each sample as it is presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc = 0; m_lfsr = 16'hACE1; m_scan = 0; m_ch = 0; m_ovr = 0; m_max = IDLE;
            for (int i = 0; i < NCH; i++) begin m_temp[i] = IDLE; m_alarm[i] = 0; end
            q.delete();
        end else begin
            m_tick = (m_presc == TICK_DIV - 1);
            m_max = 0;
            for (int i = 0; i < NCH; i++) begin
                if (m_temp[i] >= HI) m_alarm[i] = 1;
                else if (m_temp[i] <= LO) m_alarm[i] = 0;
                if (m_temp[i] > m_max) m_max = m_temp[i];
            end
            m_ovr = m_tick && m_scan;
            if (!m_scan) begin
                if (m_tick) begin m_scan = 1; m_ch = 0; q.push_back('{0, m_temp[0]}); end
            end else if (sif.sample_ready) begin
                if (m_ch == NCH - 1) m_scan = 0;
                else begin m_ch = m_ch + 1; q.push_back('{m_ch, m_temp[m_ch]}); end
            end
            if (m_tick)
                for (int i = 0; i < NCH; i++) begin
                    tgt = IDLE;
                    if (in_use[i] && (LOAD - int'(fan)) > IDLE) tgt = LOAD - int'(fan);
                    if (m_temp[i] < tgt) begin
                        m_temp[i] = m_temp[i] + 1 + int'(m_lfsr[i % 16]);
                        if (m_temp[i] > tgt) m_temp[i] = tgt;
                    end else if (m_temp[i] > tgt) begin
                        m_temp[i] = m_temp[i] - 1 - ((fan != 0) ? 1 : 0);
                        if (m_temp[i] < tgt) m_temp[i] = tgt;
                    end
                end
            if (seed_load) m_lfsr = (seed == 0) ? 16'h0001 : seed;
            else if (m_tick) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_presc = (m_presc + 1) % TICK_DIV;
        end
    end

    // Monitor: compares outputs against the model and pops samples on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("sample_valid", sif.sample_valid, m_scan);
            chk("overrun", overrun, m_ovr);
            chk("max_temp", max_temp, m_max);
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("temp%0d", i), temperature[i], m_temp[i]);
                chk($sformatf("alarm%0d", i), alarm[i], m_alarm[i]);
            end
            if (sif.sample_valid && q.size() != 0) begin
                chk("sample_ch", sif.sample_ch, q[0].ch);
                chk("sample_temp", sif.sample_temp, q[0].t);
                if (sif.sample_ready) begin
                    void'(q.pop_front());
                    hs_ch.push_back(int'(sif.sample_ch));
                    hs_count++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int prev, t, ovr_cnt, c0, t0;
    bit done, stable;

    initial begin
        in_use = '0; fan = '0; seed = '0; seed_load = 1'b0; sif.sample_ready = 1'b1;
        cyc(3);
        chk("rst_valid", sif.sample_valid, 0);
        chk("rst_ch", sif.sample_ch, 0);
        chk("rst_stemp", sif.sample_temp, 0);
        chk("rst_max", max_temp, IDLE);
        chk("rst_temp0", temperature[0], IDLE);
        chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst_n = 1'b1;

        // idle: ten ticks, one full scan each
        cyc(10 * TICK_DIV + 8);
        chk("idle_scans", hs_count, 10 * NCH);
        chk("idle_max", max_temp, IDLE);
        chk("idle_alarm", alarm, 0);

        // heat channel 0 with zero seed
        seed = 16'h0000; seed_load = 1'b1;
        cyc(1);
        seed_load = 1'b0;
        chk("seed_zero_load", dut.lfsr_q, 16'h0001);
        in_use = 4'b0001;
        prev = IDLE; done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            cyc(1);
            t = int'(temperature[0]);
            if (t != prev) begin
                chk("ramp_step", (t - prev >= 1) && (t - prev <= 2), 1);
                chk("ramp_le_load", t <= LOAD, 1);
                if (t >= HI && prev < HI) begin
                    chk("alarm_not_yet", alarm[0], 0);
                    cyc(1);
                    chk("alarm_set", alarm[0], 1);
                end
                prev = t;
                if (t == LOAD) done = 1;
            end
        end
        chk("ramp_reached", done, 1);
        cyc(3 * TICK_DIV);
        chk("ramp_hold", temperature[0], LOAD);

        // cool channel 0 with fan 3
        in_use = 4'b0000; fan = 3'd3;
        prev = LOAD; done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            cyc(1);
            t = int'(temperature[0]);
            if (t != prev) begin
                chk("cool_step", prev - t, 2);
                if (t == 72) chk("alarm_hyst_hold", alarm[0], 1);
                if (t == LO) begin
                    chk("alarm_at_lo", alarm[0], 1);
                    cyc(1);
                    chk("alarm_cleared", alarm[0], 0);
                end
                prev = t;
                if (t == IDLE) done = 1;
            end
        end
        chk("cool_reached", done, 1);
        cyc(2);
        chk("cool_max", max_temp, IDLE);

        // back-pressure across two ticks
        in_use = 4'b1010; fan = 3'd2;
        for (int c = 0; c < 40 && sif.sample_valid; c++) cyc(1);
        sif.sample_ready = 1'b0;
        done = 0;
        for (int c = 0; c < 2 * TICK_DIV && !done; c++) begin
            cyc(1);
            done = sif.sample_valid;
        end
        chk("stall_valid_rise", done, 1);
        c0 = int'(sif.sample_ch); t0 = int'(sif.sample_temp);
        ovr_cnt = 0; stable = 1;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            if (overrun) ovr_cnt++;
            if (!sif.sample_valid || int'(sif.sample_ch) != c0 || int'(sif.sample_temp) != t0) stable = 0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_ch0", c0, 0);
        chk("overrun_count", ovr_cnt, 2);
        hs_ch.delete();
        sif.sample_ready = 1'b1;
        for (int c = 0; c < 20 && sif.sample_valid; c++) cyc(1);
        chk("release_count", hs_ch.size(), NCH);
        for (int i = 0; i < NCH && i < hs_ch.size(); i++)
            chk("release_order", hs_ch[i], i);

        // seed load coincident with tick
        for (int s = 0; s < 2; s++) begin
            done = 0;
            for (int c = 0; c < 2 * TICK_DIV && !done; c++) begin
                if (m_presc == TICK_DIV - 1) done = 1;
                else cyc(1);
            end
            chk("find_tick", done, 1);
            seed = (s == 0) ? 16'h1234 : 16'h0000;
            seed_load = 1'b1;
            cyc(1);
            seed_load = 1'b0;
            chk("seed_on_tick", dut.lfsr_q, (s == 0) ? 16'h1234 : 16'h0001);
        end

        // asynchronous reset mid-scan
        in_use = 4'b1111; fan = 3'd0;
        cyc(4 * TICK_DIV);
        done = 0;
        for (int c = 0; c < 3 * TICK_DIV && !done; c++) begin
            cyc(1);
            done = sif.sample_valid && (sif.sample_ch == 2);
        end
        chk("reach_ch2", done, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", sif.sample_valid, 0);
        chk("arst_ch", sif.sample_ch, 0);
        chk("arst_stemp", sif.sample_temp, 0);
        chk("arst_temp3", temperature[3], IDLE);
        chk("arst_max", max_temp, IDLE);
        chk("arst_alarm", alarm, 0);
        chk("arst_overrun", overrun, 0);
        cyc(2);
        rst_n = 1'b1;
        hs_ch.delete();
        for (int c = 0; c < 3 * TICK_DIV && hs_ch.size() == 0; c++) cyc(1);
        chk("restart_seen", hs_ch.size() != 0, 1);
        if (hs_ch.size() != 0) chk("restart_ch0", hs_ch[0], 0);
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
